// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has fixed priority over
// load returns queued in a 2-entry FIFO, with WAW kill and starvation stall.
module wb_port_arbiter (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        flush_in,
   input  logic        wb_rf_wr_en_in,
   input  logic [4:0]  wb_rd_addr_in,
   input  logic [31:0] wb_data_in,
   input  logic        ld_valid_in,
   input  logic [4:0]  ld_rd_addr_in,
   input  logic [31:0] ld_data_in,
   output logic        ld_ready_out,
   output logic        rf_wr_en_out,
   output logic [4:0]  rf_rd_addr_out,
   output logic [31:0] rf_data_out,
   output logic        stall_out
);

   typedef enum logic [1:0] {IDLE, PENDING, STARVED} state_e;

   state_e      state_q, state_d;
   logic [1:0]  vld_q, vld_d, kill_q, kill_d;
   logic [4:0]  rd_q   [2];
   logic [31:0] data_q [2];
   logic        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [1:0]  cnt_q, cnt_d, age_q, age_d;
   logic        rf_wr_en_q, rf_wr_en_d;
   logic [4:0]  rf_rd_addr_q, rf_rd_addr_d;
   logic [31:0] rf_data_q, rf_data_d;

   logic pipe_eff, fifo_ne, pop, push, head_kill;

   assign pipe_eff     = wb_rf_wr_en_in & ~flush_in & (wb_rd_addr_in != 5'd0);
   assign fifo_ne      = (cnt_q != 2'd0);
   assign pop          = fifo_ne & ~pipe_eff;
   assign ld_ready_out = (cnt_q < 2'd2) & ~rst_in;
   assign push         = ld_valid_in & ld_ready_out;
   assign head_kill    = kill_q[rd_ptr_q];

   // Queue bookkeeping; the WAW kill is applied before the push so a load
   // arriving alongside a matching pipeline write survives (it is younger).
   always_comb begin
      vld_d  = vld_q;
      kill_d = kill_q;
      if (pipe_eff && vld_q[0] && (rd_q[0] == wb_rd_addr_in)) kill_d[0] = 1'b1;
      if (pipe_eff && vld_q[1] && (rd_q[1] == wb_rd_addr_in)) kill_d[1] = 1'b1;
      if (pop) vld_d[rd_ptr_q] = 1'b0;
      if (push) begin
         vld_d[wr_ptr_q]  = 1'b1;
         kill_d[wr_ptr_q] = (ld_rd_addr_in == 5'd0);
      end
      cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      if (!fifo_ne || pop)     age_d = 2'd0;
      else if (age_q == 2'd3)  age_d = 2'd3;
      else                     age_d = age_q + 2'd1;
   end

   // Write-port winner; address/data hold when nothing is written.
   always_comb begin
      rf_wr_en_d   = 1'b0;
      rf_rd_addr_d = rf_rd_addr_q;
      rf_data_d    = rf_data_q;
      if (pipe_eff) begin
         rf_wr_en_d   = 1'b1;
         rf_rd_addr_d = wb_rd_addr_in;
         rf_data_d    = wb_data_in;
      end else if (pop && !head_kill) begin
         rf_wr_en_d   = 1'b1;
         rf_rd_addr_d = rd_q[rd_ptr_q];
         rf_data_d    = data_q[rd_ptr_q];
      end
   end

   always_comb begin
      state_d = state_q;
      if (cnt_d == 2'd0)      state_d = IDLE;
      else if (age_d == 2'd3) state_d = STARVED;
      else                    state_d = PENDING;
   end

   always_comb begin
      stall_out = (state_q == STARVED);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         vld_q        <= 2'b00;
         kill_q       <= 2'b00;
         rd_ptr_q     <= 1'b0;
         wr_ptr_q     <= 1'b0;
         cnt_q        <= 2'd0;
         age_q        <= 2'd0;
         rf_wr_en_q   <= 1'b0;
         rf_rd_addr_q <= 5'd0;
         rf_data_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         vld_q        <= vld_d;
         kill_q       <= kill_d;
         rd_ptr_q     <= rd_ptr_d;
         wr_ptr_q     <= wr_ptr_d;
         cnt_q        <= cnt_d;
         age_q        <= age_d;
         rf_wr_en_q   <= rf_wr_en_d;
         rf_rd_addr_q <= rf_rd_addr_d;
         rf_data_q    <= rf_data_d;
      end
   end

   // Entry payload needs no reset: it is only read while its slot is occupied.
   always_ff @(posedge clk_in) begin
      if (push) begin
         rd_q[wr_ptr_q]   <= ld_rd_addr_in;
         data_q[wr_ptr_q] <= ld_data_in;
      end
   end

   assign rf_wr_en_out   = rf_wr_en_q;
   assign rf_rd_addr_out = rf_rd_addr_q;
   assign rf_data_out    = rf_data_q;

endmodule
